// File: rtl/knn_distance_engine.sv
// knn_distance_engine: streaming multi-lane distance engine for the KNN classifier.
// Accumulates squared-Euclidean or Manhattan distance between a query and a
// training vector, LANES signed elements per accepted beat, with a saturating
// accumulator, and hands the result plus the training class tag downstream.
module knn_distance_engine #(
  parameter int unsigned W        = 8,
  parameter int unsigned LANES    = 4,
  parameter int unsigned FEATURES = 64,
  parameter int unsigned ACC_W    = 24,
  parameter int unsigned TYPE_W   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  mode,
  input  logic [TYPE_W-1:0]     in_type,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [LANES*W-1:0]    in_query,
  input  logic [LANES*W-1:0]    in_train,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ACC_W-1:0]      out_distance,
  output logic [TYPE_W-1:0]     out_type,
  output logic                  out_saturated,
  output logic                  busy
);

  localparam int unsigned BEATS  = FEATURES / LANES;
  localparam int unsigned CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned TERM_W = 2 * W + 2;
  localparam int unsigned SUM_W  = TERM_W + $clog2(LANES) + 1;
  localparam int unsigned TOT_W  = ((ACC_W > SUM_W) ? ACC_W : SUM_W) + 1;

  if ((FEATURES % LANES) != 0) begin : g_bad_features
    $error("knn_distance_engine: FEATURES must be a multiple of LANES");
  end

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    OUTPUT
  } state_t;

  state_t              state, state_next;
  logic                mode_q;
  logic [TYPE_W-1:0]   type_q;
  logic [ACC_W-1:0]    acc;
  logic [CNT_W-1:0]    beat_cnt;

  logic signed [W:0]        q_e, t_e, d;
  logic signed [TERM_W-1:0] d_x, prod;
  logic [W:0]               ad;
  logic [TERM_W-1:0]        term;
  logic [SUM_W-1:0]         beat_sum;
  logic [TOT_W-1:0]         acc_sum;
  logic [ACC_W-1:0]         acc_next;
  logic                     clip;
  logic                     beat_fire;
  logic                     last_beat;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic and state-decoded handshake outputs
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_next = ACCUM;
      end
      ACCUM: begin
        in_ready = 1'b1;
        if (in_valid && last_beat) state_next = OUTPUT;
      end
      OUTPUT: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Per-lane distance terms summed at full precision, then saturating add
  always_comb begin
    q_e      = '0;
    t_e      = '0;
    d        = '0;
    d_x      = '0;
    prod     = '0;
    ad       = '0;
    term     = '0;
    beat_sum = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      q_e  = {in_query[k*W+W-1], in_query[k*W +: W]};
      t_e  = {in_train[k*W+W-1], in_train[k*W +: W]};
      d    = q_e - t_e;
      d_x  = TERM_W'(d);
      prod = d_x * d_x;
      ad   = d[W] ? -d : d;
      term = mode_q ? TERM_W'(ad) : prod;
      beat_sum = beat_sum + SUM_W'(term);
    end
    acc_sum   = TOT_W'(acc) + TOT_W'(beat_sum);
    clip      = |acc_sum[TOT_W-1:ACC_W];
    acc_next  = clip ? '1 : acc_sum[ACC_W-1:0];
    beat_fire = in_valid && (state == ACCUM);
    last_beat = (beat_cnt == CNT_W'(BEATS - 1));
  end

  // Datapath: latch configuration at start, accumulate beats, load result
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q        <= 1'b0;
      type_q        <= '0;
      acc           <= '0;
      beat_cnt      <= '0;
      out_distance  <= '0;
      out_type      <= '0;
      out_saturated <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mode_q        <= mode;
            type_q        <= in_type;
            acc           <= '0;
            beat_cnt      <= '0;
            out_saturated <= 1'b0;
          end
        end
        ACCUM: begin
          if (beat_fire) begin
            acc      <= acc_next;
            beat_cnt <= beat_cnt + 1'b1;
            if (clip) out_saturated <= 1'b1;
            if (last_beat) begin
              out_distance <= acc_next;
              out_type     <= type_q;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
